// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_arbiter_pkg                                             |
// | Description : Constants and types shared by the data-memory arbiter, the   |
// |               data memory and the core: bus widths, default aging limit    |
// |               and the read-owner tag encoding.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package dmem_arbiter_pkg;

  localparam int DMEM_DATA_W  = 16;
  localparam int DMEM_ADDR_W  = 16;
  localparam int MAX_WAIT_DEF = 8;
  localparam int AGE_W        = 8;
  localparam int STALL_W      = 16;

  // Which port a read in flight belongs to; NONE for writes and idle cycles.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_C    = 2'd1,
    OWN_A    = 2'd2
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_age.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_arb_age                                                 |
// | Description : Saturating "lost arbitration" counter. Counts edges where    |
// |               req=1 and win=0, saturating at MAX_VAL. With HOLD_ON_IDLE=0  |
// |               the count clears whenever the port wins or stops requesting  |
// |               (aging use); with HOLD_ON_IDLE=1 it only clears on clr       |
// |               (statistics use). clr has priority over counting.            |
// | Ports       : clk, reset (async active-low), clr, req, win -> cnt          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dmem_arb_age
  import dmem_arbiter_pkg::*;
#(
  parameter int          WIDTH        = AGE_W,
  parameter int unsigned MAX_VAL      = MAX_WAIT_DEF,
  parameter bit          HOLD_ON_IDLE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             req,
  input  logic             win,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (req && !win) begin
      if (r_cnt < C_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (!HOLD_ON_IDLE) begin
      r_cnt <= '0;
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_arbiter                                                 |
// | Description : Shares the single-port data memory between the core port (C) |
// |               and an auxiliary loader/DMA/debug port (A). Core has         |
// |               priority; an aging counter lets A win after MAX_WAIT lost    |
// |               edges. One access per cycle, registered memory command,      |
// |               read data steered back by a registered owner tag.            |
// | Ports       : clk, reset (async active-low)                                |
// |               c_req/c_we/c_byte/c_addr/c_wdata -> c_gnt/c_rvalid/c_rdata   |
// |               a_req/a_we/a_byte/a_addr/a_wdata -> a_gnt/a_rvalid/a_rdata   |
// |               mem_rd/mem_we/mem_byte/mem_addr/mem_wdata, mem_rdata         |
// |               DMEM_ARB_STATS_EN adds stats_clr, c_stall_cnt, a_stall_cnt   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic              c_byte,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_byte,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              mem_rd,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [STALL_W-1:0] c_stall_cnt,
  output logic [STALL_W-1:0] a_stall_cnt
`endif
);

  logic             w_c_win;
  logic             w_a_win;
  logic [AGE_W-1:0] w_age;

  logic              r_c_gnt;
  logic              r_a_gnt;
  logic              r_mem_rd;
  logic              r_mem_we;
  logic              r_mem_byte;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  owner_e            r_owner;
  logic              r_c_rvalid;
  logic              r_a_rvalid;
  logic [DATA_W-1:0] r_c_rdata;
  logic [DATA_W-1:0] r_a_rdata;

  // A wins when alone, or when it has aged out against a competing core.
  always_comb begin
    w_a_win = a_req && (!c_req || (w_age >= AGE_W'(MAX_WAIT)));
    w_c_win = c_req && !w_a_win;
  end

  dmem_arb_age #(
    .WIDTH        (AGE_W),
    .MAX_VAL      (MAX_WAIT),
    .HOLD_ON_IDLE (1'b0)
  ) u_age (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .req   (a_req),
    .win   (w_a_win),
    .cnt   (w_age)
  );

  // Command issue and read-return tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_c_gnt     <= 1'b0;
      r_a_gnt     <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_byte  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_owner     <= OWN_NONE;
      r_c_rvalid  <= 1'b0;
      r_a_rvalid  <= 1'b0;
      r_c_rdata   <= '0;
      r_a_rdata   <= '0;
    end else begin
      r_c_gnt <= w_c_win;
      r_a_gnt <= w_a_win;

      if (w_c_win) begin
        r_mem_rd    <= !c_we;
        r_mem_we    <= c_we;
        r_mem_byte  <= c_byte;
        r_mem_addr  <= c_addr;
        r_mem_wdata <= c_wdata;
        r_owner     <= c_we ? OWN_NONE : OWN_C;
      end else if (w_a_win) begin
        r_mem_rd    <= !a_we;
        r_mem_we    <= a_we;
        r_mem_byte  <= a_byte;
        r_mem_addr  <= a_addr;
        r_mem_wdata <= a_wdata;
        r_owner     <= a_we ? OWN_NONE : OWN_A;
      end else begin
        // Idle: address, data and size hold so the memory bus stays quiet.
        r_mem_rd <= 1'b0;
        r_mem_we <= 1'b0;
        r_owner  <= OWN_NONE;
      end

      // Memory returns data the cycle after mem_rd; the tag follows it.
      r_c_rvalid <= (r_owner == OWN_C);
      r_a_rvalid <= (r_owner == OWN_A);

      // Capture the returned word so each port's rdata holds between reads.
      if (r_c_rvalid) begin
        r_c_rdata <= mem_rdata;
      end
      if (r_a_rvalid) begin
        r_a_rdata <= mem_rdata;
      end
    end
  end

  assign c_gnt     = r_c_gnt;
  assign a_gnt     = r_a_gnt;
  assign mem_rd    = r_mem_rd;
  assign mem_we    = r_mem_we;
  assign mem_byte  = r_mem_byte;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign c_rvalid  = r_c_rvalid;
  assign a_rvalid  = r_a_rvalid;
  assign c_rdata   = r_c_rvalid ? mem_rdata : r_c_rdata;
  assign a_rdata   = r_a_rvalid ? mem_rdata : r_a_rdata;

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_age #(
    .WIDTH        (STALL_W),
    .MAX_VAL      (32'h0000_FFFF),
    .HOLD_ON_IDLE (1'b1)
  ) u_c_stall (
    .clk   (clk),
    .reset (reset),
    .clr   (stats_clr),
    .req   (c_req),
    .win   (w_c_win),
    .cnt   (c_stall_cnt)
  );

  dmem_arb_age #(
    .WIDTH        (STALL_W),
    .MAX_VAL      (32'h0000_FFFF),
    .HOLD_ON_IDLE (1'b1)
  ) u_a_stall (
    .clk   (clk),
    .reset (reset),
    .clr   (stats_clr),
    .req   (a_req),
    .win   (w_a_win),
    .cnt   (a_stall_cnt)
  );
`endif

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (dataMemo) between two requesters: the core load/store path (port C) and an auxiliary loader/DMA/debug port (port A).
- Sits between Core and dataMemo in top and replaces the direct MemR/MemW/resAdd wiring.
- Core has priority; an aging counter guarantees port A forward progress.
- One access issued per cycle. Memory command outputs are registered. Read data is routed back to the issuing port via a registered owner tag.

Parameters:
- DATA_W, 16, data width
- ADDR_W, 16, address width
- MAX_WAIT, 8, cycles port A may wait before it overrides core priority; legal range 1..255

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- c_req  in  1  core access request
- c_we  in  1  core write (1) / read (0)
- c_byte  in  1  core byte (1) / word (0) access
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core write data
- c_gnt  out  1  core request accepted
- c_rvalid  out  1  core read data valid
- c_rdata  out  DATA_W  core read data
- a_req, a_we, a_byte, a_addr, a_wdata  in  1/1/1/ADDR_W/DATA_W  aux request fields, same meaning as core
- a_gnt, a_rvalid, a_rdata  out  1/1/DATA_W  aux grant and response
- mem_rd  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_byte  out  1  memory byte access
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_rd

Behaviour:
- Reset (reset=0, asynchronous): all gnt, rvalid, mem_rd and mem_we = 0; mem_addr, mem_wdata and mem_byte = 0; age = 0; owner tag = none. Reset mid-access drops any pending rvalid.
- Handshake: requester holds req and all fields stable until it sees gnt=1.
  - gnt is a registered one-cycle pulse per accepted access.
  - If req is still high at the edge ending the gnt cycle, it counts as a new request.
  - Withdrawing req before gnt is legal; no access is issued.
- Arbitration at each edge, using the sampled req values:
  - Only one port requesting: that port wins.
  - Both requesting and age >= MAX_WAIT: A wins.
  - Both requesting otherwise: C wins.
  - Neither requesting: idle; mem_rd=mem_we=0 next cycle.
- Timing for a request sampled at the edge ending cycle N:
  - Cycle N+1: gnt_x=1; mem_* driven from the winner's fields; mem_rd = ~we and mem_we = we; owner tag registered.
  - Cycle N+2: for reads, rvalid_x=1 and rdata_x = mem_rdata (combinational pass-through). The other port's rdata is held at its last value.
  - Writes produce no rvalid.
- Aging counter: 8-bit.
  - Increments at each edge where a_req=1 and A loses.
  - Cleared when A wins or a_req=0.
  - Saturates at MAX_WAIT.
- Back-to-back throughput: one access per cycle; alternating reads from both ports overlap, each return tagged correctly.
- Idle mem_addr and mem_wdata hold their previous values.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs c_stall_cnt[15:0] and a_stall_cnt[15:0].
  - Each counts edges where the port's req=1 and it did not win; saturating at 16'hFFFF; cleared by reset.
  - Adds input stats_clr, which synchronously zeroes both counters. If stats_clr coincides with an increment, the clear wins.
- Undefined: the stats ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds: owner tag encoding (OWN_NONE=2'd0, OWN_C=2'd1, OWN_A=2'd2), default MAX_WAIT, and DATA_W/ADDR_W constants shared with dataMemo and Core.
- One natural sub-module, dmem_arb_age: the saturating aging counter with a win/lose/req interface, reused for the stats counters.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release with no req -> all outputs 0, mem_rd/mem_we stay 0 for 10 cycles.
- Core read alone: c_req=1, c_we=0, c_addr=16'h0040, mem_rdata=16'hBEEF -> c_gnt pulse at N+1 with mem_rd=1 and mem_addr=16'h0040; c_rvalid=1 and c_rdata=16'hBEEF at N+2; a_rvalid stays 0.
- Contention aging with MAX_WAIT=8: c_req and a_req held high continuously -> C wins 8 consecutive grants, A wins the 9th, C the next; pattern repeats.
- Interleaved reads: C reads addr 16'h0010 (data 16'h1111), A reads 16'h0020 (16'h2222) in consecutive grant cycles -> c_rdata=16'h1111 and a_rdata=16'h2222, each with its own rvalid, one cycle apart.
- Write, byte: a_req=1, a_we=1, a_byte=1, a_addr=16'h0005, a_wdata=16'h00AB -> mem_we=1 and mem_byte=1 for one cycle; no a_rvalid.
- Reset mid-read: assert reset during the cycle a read is granted -> no rvalid follows; the first access after reset release is issued normally.
